// File: rtl/conv_ff_pkg.sv
// Shared types and constants for the convertible flip-flop bank.
package conv_ff_pkg;

    // Per-cycle behaviour of every bit in the bank.
    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_t;

    // Resolution of the S=R=1 input in SR mode.
    localparam int SR_HOLD = 0;
    localparam int SR_SET  = 1;
    localparam int SR_RST  = 2;

endpackage

// File: rtl/conv_ff_next.sv
// Combinational next-state function of one convertible flip-flop bit.
module conv_ff_next
    import conv_ff_pkg::*;
#(
    parameter int SR_POLICY = SR_SET
) (
    input  mode_t mode,
    input  logic  a,
    input  logic  b,
    input  logic  q,
    output logic  d
);

    // Select the D/T/SR/JK characteristic equation for this bit.
    always_comb begin
        // NOTE: default first so every path assigns d and no latch is inferred.
        d = q;
        case (mode)
            MODE_D:  d = a;
            MODE_T:  d = q ^ a;
            MODE_SR: begin
                if (a && b) begin
                    if (SR_POLICY == SR_SET)      d = 1'b1;
                    else if (SR_POLICY == SR_RST) d = 1'b0;
                    else                          d = q;
                end else begin
                    d = a | (~b & q);
                end
            end
            MODE_JK: d = (a & ~q) | (~b & q);
            default: d = q;
        endcase
    end

endmodule

// File: rtl/conv_ff_bank.sv
// Bank of WIDTH runtime-convertible flip-flops (D/T/SR/JK) with sticky
// SR-conflict flags and a saturating conflict counter.
// Optional macro CONV_FF_BANK_CHG_EN adds a registered per-bit change pulse (chg).
module conv_ff_bank
    import conv_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
    parameter int               SR_POLICY = SR_SET,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             mode_busy,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
`ifdef CONV_FF_BANK_CHG_EN
    ,
    output logic [WIDTH-1:0] chg
`endif
);

    mode_t            mode_q;
    logic             update;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] hit;

    // A requested mode differing from the active one costs one hold edge.
    assign mode_busy = (mode_t'(mode) != mode_q);
    assign update    = en & ~mode_busy;
    assign hit       = (update && mode_q == MODE_SR) ? (a & b) : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        conv_ff_next #(.SR_POLICY(SR_POLICY)) u_next (
            .mode (mode_q),
            .a    (a[i]),
            .b    (b[i]),
            .q    (q[i]),
            .d    (d_next[i])
        );
    end

    // State bits and the active mode register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            q      <= RST_VAL;
            mode_q <= MODE_D;
        end else begin
            mode_q <= mode_t'(mode);
            if (update) q <= d_next;
        end
    end

    // Sticky per-bit conflict flags; a fresh conflict beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n)       conflict <= '0;
        else if (clr_err) conflict <= hit;
        else              conflict <= conflict | hit;
    end

    // Saturating count of cycles that saw any conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (clr_err) begin
            conflict_cnt <= (|hit) ? CNT_W'(1) : '0;
        end else if ((|hit) && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

`ifdef CONV_FF_BANK_CHG_EN
    // One-cycle pulse on bits whose value changed at the last functional edge.
    always_ff @(posedge clk) begin
        if (!rst_n) chg <= '0;
        else        chg <= update ? (d_next ^ q) : '0;
    end
`endif

endmodule

// File: tb/tb_conv_ff_bank.sv
// Self-checking bench: three banks (set-dominant, hold, reset-dominant with a
// 2-bit counter) share one stimulus stream and are compared every cycle
// against a behavioural model, plus directed vectors and corner sequences.
module tb_conv_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;

    logic [7:0] q0, q1, q2;
    logic       busy0, busy1, busy2;
    logic [7:0] cf0, cf1, cf2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
`ifdef CONV_FF_BANK_CHG_EN
    logic [7:0] chg0, chg1, chg2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q0), .mode_busy(busy0), .conflict(cf0), .conflict_cnt(cnt0)
`ifdef CONV_FF_BANK_CHG_EN
        , .chg(chg0)
`endif
    );
    conv_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q1), .mode_busy(busy1), .conflict(cf1), .conflict_cnt(cnt1)
`ifdef CONV_FF_BANK_CHG_EN
        , .chg(chg1)
`endif
    );
    conv_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q2), .mode_busy(busy2), .conflict(cf2), .conflict_cnt(cnt2)
`ifdef CONV_FF_BANK_CHG_EN
        , .chg(chg2)
`endif
    );

    // Behavioural model state, one slot per bank.
    int         pol  [3] = '{1, 0, 2};
    int         cmax [3] = '{255, 255, 3};
    logic [7:0] m_q  [3];
    logic [7:0] m_cf [3];
    int         m_cnt[3];
    logic [7:0] m_chg[3];
    logic [1:0] m_mode;
    bit         m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flip-flop characteristic tables written bit by bit.
    function automatic logic [7:0] model_next(input int p, input logic [1:0] md,
                                              input logic [7:0] qq, input logic [7:0] aa,
                                              input logic [7:0] bb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = qq[i];
            if (md == 2'd0) r[i] = aa[i];
            else if (md == 2'd1) r[i] = aa[i] ? ~qq[i] : qq[i];
            else if (aa[i] && bb[i]) begin
                if (md == 2'd3) r[i] = ~qq[i];
                else if (p == 1) r[i] = 1'b1;
                else if (p == 2) r[i] = 1'b0;
            end else if (aa[i]) r[i] = 1'b1;
            else if (bb[i]) r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic compare_all();
        check("q0", q0, m_q[0]);   check("q1", q1, m_q[1]);   check("q2", q2, m_q[2]);
        check("cf0", cf0, m_cf[0]); check("cf1", cf1, m_cf[1]); check("cf2", cf2, m_cf[2]);
        check("cnt0", cnt0, m_cnt[0]); check("cnt1", cnt1, m_cnt[1]); check("cnt2", cnt2, m_cnt[2]);
`ifdef CONV_FF_BANK_CHG_EN
        check("chg0", chg0, m_chg[0]); check("chg1", chg1, m_chg[1]); check("chg2", chg2, m_chg[2]);
`endif
    endtask

    // Check combinational busy, advance one edge, update model, compare.
    task automatic tick();
        logic [7:0] nq[3], nc[3], nchg[3], hit;
        int         ncnt[3];
        logic       busy_e, upd;
        #1;
        busy_e = (mode != m_mode);
        if (m_valid) begin
            check("busy0", busy0, busy_e);
            check("busy1", busy1, busy_e);
            check("busy2", busy2, busy_e);
        end
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                nq[k] = 8'hA5; nc[k] = 8'h00; ncnt[k] = 0; nchg[k] = 8'h00;
            end else begin
                upd   = en && !busy_e;
                hit   = (upd && m_mode == 2'd2) ? (a & b) : 8'h00;
                nq[k] = upd ? model_next(pol[k], m_mode, m_q[k], a, b) : m_q[k];
                if (clr_err) begin
                    nc[k]   = hit;
                    ncnt[k] = (hit != 0) ? 1 : 0;
                end else begin
                    nc[k]   = m_cf[k] | hit;
                    ncnt[k] = (hit != 0 && m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
                end
                nchg[k] = nq[k] ^ m_q[k];
            end
        end
        @(posedge clk);
        #1;
        m_mode = rst_n ? mode : 2'd0;
        if (!rst_n) m_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_q[k] = nq[k]; m_cf[k] = nc[k]; m_cnt[k] = ncnt[k]; m_chg[k] = nchg[k];
        end
        if (m_valid) compare_all();
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] md,
                         input logic [7:0] aa, input logic [7:0] bb, input logic c);
        rst_n = r; en = e; mode = md; a = aa; b = bb; clr_err = c;
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] exp_q;
        logic [7:0] exp_cf;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Directed vectors for the set-dominant bank (dut0, RST_VAL=A5).
        tbl[0]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'h00, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 2'd0, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'h00, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 2'd1, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'h00, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 2'd1, 8'h0F, 8'h00, 1'b0, 8'h33, 8'h00, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 8'h0F, 8'h00, 1'b0, 8'h3C, 8'h00, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h3C, 8'h00, 8'd0};
        tbl[6]  = '{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 2'd2, 8'h81, 8'h01, 1'b0, 8'h00, 8'h00, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 8'h81, 8'h01, 1'b0, 8'h81, 8'h01, 8'd1};
        tbl[9]  = '{1'b1, 1'b1, 2'd2, 8'h81, 8'h01, 1'b0, 8'h81, 8'h01, 8'd2};
        tbl[10] = '{1'b1, 1'b1, 2'd2, 8'h81, 8'h01, 1'b0, 8'h81, 8'h01, 8'd3};
        tbl[11] = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 8'h81, 8'h00, 8'd0};
        tbl[12] = '{1'b1, 1'b0, 2'd2, 8'hFF, 8'hFF, 1'b0, 8'h81, 8'h00, 8'd0};
        tbl[13] = '{1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0, 8'h81, 8'h00, 8'd0};
        tbl[14] = '{1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0, 8'h7E, 8'h00, 8'd0};
        tbl[15] = '{1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0, 8'h81, 8'h00, 8'd0};

        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        #2;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr);
            tick();
            check($sformatf("vec%0d_q", i), q0, tbl[i].exp_q);
            check($sformatf("vec%0d_cf", i), cf0, tbl[i].exp_cf);
            check($sformatf("vec%0d_cnt", i), cnt0, tbl[i].exp_cnt);
        end

        // SR policy variants and counter saturation, starting from q=FF.
        drive(1'b1, 1'b1, 2'd0, 8'hFF, 8'h00, 1'b0); tick(); tick();
        check("seq_pre_q2", q2, 8'hFF);
        drive(1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0); tick();
        drive(1'b1, 1'b1, 2'd2, 8'hF0, 8'hF0, 1'b0); tick();
        check("pol_set_q", q0, 8'hFF);
        check("pol_hold_q", q1, 8'hFF);
        check("pol_rst_q", q2, 8'h0F);
        check("pol_rst_cf", cf2, 8'hF0);
        for (int i = 0; i < 4; i++) tick();
        check("sat_cnt2", cnt2, 2'd3);
        check("nosat_cnt0", cnt0, 8'd5);
        drive(1'b1, 1'b1, 2'd2, 8'h01, 8'h01, 1'b1); tick();
        check("clr_win_cnt2", cnt2, 2'd1);
        check("clr_win_cf2", cf2, 8'h01);
        check("clr_win_cnt0", cnt0, 8'd1);

        // Reset in the middle of a pending mode change.
        drive(1'b0, 1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0); tick();
        check("rst_mid_q", q0, 8'hA5);
        drive(1'b1, 1'b1, 2'd0, 8'h5A, 8'h00, 1'b0); tick();
        check("rst_mode_d", q0, 8'h5A);

`ifdef CONV_FF_BANK_CHG_EN
        drive(1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0); tick();
        drive(1'b1, 1'b1, 2'd0, 8'h12, 8'h00, 1'b0); tick();
        check("chg_pulse", chg0, 8'h12);
        tick();
        check("chg_clear", chg0, 8'h00);
        drive(1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 1'b0); tick();
        check("chg_en_low", chg0, 8'h00);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            en      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) mode = 2'($urandom_range(0, 3));
            a       = 8'($urandom);
            b       = 8'($urandom);
            clr_err = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
